// File: rtl/therm_decoder_if.sv
// Signal bundle for therm_decoder: enable, code input handshake, sweep request and decoded outputs.
interface therm_decoder_if;
  logic       en;
  logic       in_valid;
  logic [2:0] code;
  logic       in_ready;
  logic       sweep_start;
  logic [6:0] therm;
  logic [7:0] onehot;
  logic [2:0] code_out;
  logic       out_valid;
  logic       busy;

  modport master (
    output en, in_valid, code, sweep_start,
    input  in_ready, therm, onehot, code_out, out_valid, busy
  );

  modport slave (
    input  en, in_valid, code, sweep_start,
    output in_ready, therm, onehot, code_out, out_valid, busy
  );
endinterface

// File: rtl/therm_decoder.sv
// therm_decoder: 3-bit code to registered thermometer/one-hot patterns with a one-cycle out_valid pulse.
// The automatic 0..7 sweep (SWEEP state, dwell counter) exists only when THERM_DECODER_SWEEP_EN is defined.
module therm_decoder #(
  parameter int unsigned SWEEP_DWELL = 1
) (
  input  logic           clk,
  input  logic           rst,
  therm_decoder_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // A dwell of zero would never advance, so it behaves as one cycle.
  localparam int unsigned DWELL_EFF  = (SWEEP_DWELL == 0) ? 1 : SWEEP_DWELL;
  localparam logic [7:0]  DWELL_LAST = 8'(DWELL_EFF - 1);

  function automatic logic [6:0] f_therm(input logic [2:0] c);
    logic [6:0] t;
    t = 7'd0;
    for (int i = 0; i < 7; i++) begin
      if (3'(i) < c) t[i] = 1'b1;
      else           t[i] = 1'b0;
    end
    return t;
  endfunction

  function automatic logic [7:0] f_onehot(input logic [2:0] c);
    logic [7:0] t;
    t    = 8'd0;
    t[c] = 1'b1;
    return t;
  endfunction

  state_t     r_state;
  logic [6:0] r_therm;
  logic [7:0] r_onehot;
  logic [2:0] r_code_out;
  logic       r_out_valid;
  logic       w_in_ready;

`ifdef THERM_DECODER_SWEEP_EN
  logic [7:0] r_dwell;
  logic       r_busy;
  logic       w_start;
  logic [2:0] w_next_code;

  assign w_next_code = r_code_out + 3'd1;

  // sweep_start outranks a simultaneous in_valid, so in_ready drops while it is asserted
  always_comb begin
    w_start    = bus.en && (r_state == ST_IDLE) && bus.sweep_start;
    w_in_ready = bus.en && (r_state == ST_IDLE) && !bus.sweep_start;
  end

  // Main FSM: reset/enable clear, direct transfers, and the dwell-paced sweep
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      r_state     <= ST_IDLE;
      r_dwell     <= 8'd0;
      r_therm     <= 7'd0;
      r_onehot    <= 8'd0;
      r_code_out  <= 3'd0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_SWEEP;
            r_dwell     <= 8'd0;
            r_therm     <= f_therm(3'd0);
            r_onehot    <= f_onehot(3'd0);
            r_code_out  <= 3'd0;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end else if (bus.in_valid) begin
            r_therm     <= f_therm(bus.code);
            r_onehot    <= f_onehot(bus.code);
            r_code_out  <= bus.code;
            r_out_valid <= 1'b1;
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (r_dwell == DWELL_LAST) begin
            r_dwell <= 8'd0;
            // Code 7 has finished its dwell: leave the outputs on 7 and go idle
            if (r_code_out == 3'd7) begin
              r_state     <= ST_IDLE;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b0;
            end else begin
              r_therm     <= f_therm(w_next_code);
              r_onehot    <= f_onehot(w_next_code);
              r_code_out  <= w_next_code;
              r_out_valid <= 1'b1;
            end
          end else begin
            r_dwell     <= r_dwell + 8'd1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_dwell     <= 8'd0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
`else
  logic [8:0] w_unused_sweep;

  assign w_unused_sweep = {bus.sweep_start, DWELL_LAST};

  // Without the sweep, readiness is simply the enable
  always_comb begin
    w_in_ready = bus.en;
  end

  // Main FSM: reset/enable clear and direct transfers; the state never leaves IDLE
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      r_state     <= ST_IDLE;
      r_therm     <= 7'd0;
      r_onehot    <= 8'd0;
      r_code_out  <= 3'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_therm     <= f_therm(bus.code);
            r_onehot    <= f_onehot(bus.code);
            r_code_out  <= bus.code;
            r_out_valid <= 1'b1;
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.therm     = r_therm;
  assign bus.onehot    = r_onehot;
  assign bus.code_out  = r_code_out;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_therm_decoder.sv
// Directed self-checking bench for therm_decoder (SWEEP_DWELL=3); sweep scenarios run when THERM_DECODER_SWEEP_EN is defined.
module tb_therm_decoder;
  logic       clk;
  logic       rst;
  int         checks = 0;
  int         errors = 0;
  int         pulses;
  logic [6:0] exp_therm [0:7];
  logic [7:0] exp_onehot [0:7];

  therm_decoder_if bus();

  therm_decoder #(.SWEEP_DWELL(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outs(input string tag, input logic [6:0] t, input logic [7:0] oh,
                            input logic [2:0] c, input logic ov, input logic bsy);
    check($sformatf("%s.therm", tag),     32'(bus.therm),     32'(t));
    check($sformatf("%s.onehot", tag),    32'(bus.onehot),    32'(oh));
    check($sformatf("%s.code_out", tag),  32'(bus.code_out),  32'(c));
    check($sformatf("%s.out_valid", tag), 32'(bus.out_valid), 32'(ov));
    check($sformatf("%s.busy", tag),      32'(bus.busy),      32'(bsy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_therm[0] = 7'b0000000; exp_onehot[0] = 8'b00000001;
    exp_therm[1] = 7'b0000001; exp_onehot[1] = 8'b00000010;
    exp_therm[2] = 7'b0000011; exp_onehot[2] = 8'b00000100;
    exp_therm[3] = 7'b0000111; exp_onehot[3] = 8'b00001000;
    exp_therm[4] = 7'b0001111; exp_onehot[4] = 8'b00010000;
    exp_therm[5] = 7'b0011111; exp_onehot[5] = 8'b00100000;
    exp_therm[6] = 7'b0111111; exp_onehot[6] = 8'b01000000;
    exp_therm[7] = 7'b1111111; exp_onehot[7] = 8'b10000000;

    rst = 1'b1;
    bus.en = 1'b0;
    bus.in_valid = 1'b0;
    bus.code = 3'd0;
    bus.sweep_start = 1'b0;
    step();
    step();
    check_outs("reset", 7'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd0);

    rst = 1'b0;
    bus.en = 1'b1;
    #1;
    check("idle.in_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back transfers of codes 0..7
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = 1'b1;
      bus.code = 3'(c);
      step();
      check_outs($sformatf("xfer%0d", c), exp_therm[c], exp_onehot[c], 3'(c), 1'b1, 1'b0);
    end
    bus.in_valid = 1'b0;
    step();
    check_outs("hold1", 7'b1111111, 8'b10000000, 3'd7, 1'b0, 1'b0);
    step();
    check_outs("hold2", 7'b1111111, 8'b10000000, 3'd7, 1'b0, 1'b0);

    bus.in_valid = 1'b1;
    bus.code = 3'd3;
    step();
    check_outs("c3", 7'b0000111, 8'b00001000, 3'd3, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    step();
    check_outs("c3hold", 7'b0000111, 8'b00001000, 3'd3, 1'b0, 1'b0);

    // Enable low clears and blocks transfers
    bus.en = 1'b0;
    bus.in_valid = 1'b1;
    bus.code = 3'd5;
    #1;
    check("en_low.in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check_outs("en_low", 7'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    step();
    check_outs("en_low2", 7'd0, 8'd0, 3'd0, 1'b0, 1'b0);

    // Reset outranks an accepted transfer
    bus.en = 1'b1;
    bus.code = 3'd6;
    rst = 1'b1;
    step();
    check_outs("rst_prio", 7'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check_outs("after_rst", 7'd0, 8'd0, 3'd0, 1'b0, 1'b0);

`ifndef THERM_DECODER_SWEEP_EN
    bus.sweep_start = 1'b1;
    #1;
    check("nosweep.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.sweep_start = 1'b0;
    check_outs("nosweep", 7'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.code = 3'd2;
    step();
    check_outs("nosweep_c2", 7'b0000011, 8'b00000100, 3'd2, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    step();
    check_outs("nosweep_hold", 7'b0000011, 8'b00000100, 3'd2, 1'b0, 1'b0);
`else
    // Sweep start collides with in_valid(code 4); sweep wins
    bus.sweep_start = 1'b1;
    bus.in_valid = 1'b1;
    bus.code = 3'd4;
    #1;
    check("start.in_ready", 32'(bus.in_ready), 32'd0);
    pulses = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      check_outs($sformatf("sweep%0d", k), exp_therm[k/3], exp_onehot[k/3], 3'(k/3),
                 (k % 3 == 0) ? 1'b1 : 1'b0, 1'b1);
      if (bus.out_valid === 1'b1) pulses++;
      bus.sweep_start = (k >= 3 && k <= 5) ? 1'b1 : 1'b0;
      bus.in_valid = (k < 20) ? 1'b1 : 1'b0;
      bus.code = 3'd6;
      #1;
      check($sformatf("sweep%0d.in_ready", k), 32'(bus.in_ready), 32'd0);
    end
    check("sweep.pulses", 32'(pulses), 32'd8);
    step();
    check_outs("sweep_end", 7'b1111111, 8'b10000000, 3'd7, 1'b0, 1'b0);
    step();
    check_outs("sweep_idle", 7'b1111111, 8'b10000000, 3'd7, 1'b0, 1'b0);

    // Enable dropped while the sweep sits on code 3
    bus.sweep_start = 1'b1;
    step();
    bus.sweep_start = 1'b0;
    repeat (9) step();
    check_outs("at_c3", 7'b0000111, 8'b00001000, 3'd3, 1'b1, 1'b1);
    bus.en = 1'b0;
    step();
    check_outs("en_abort", 7'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    bus.en = 1'b1;
    step();
    check_outs("no_resume", 7'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    check("no_resume.in_ready", 32'(bus.in_ready), 32'd1);

    // Reset mid-sweep: no further pulses
    bus.sweep_start = 1'b1;
    step();
    bus.sweep_start = 1'b0;
    repeat (7) step();
    check_outs("at_c2", 7'b0000011, 8'b00000100, 3'd2, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    check_outs("rst_abort", 7'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    pulses = 0;
    repeat (30) begin
      step();
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    check("rst_abort.pulses", 32'(pulses), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
